// File: rtl/phase_sequencer_timer.sv
// Phase sequencer/timer: after a start request it steps through NUM_PHASES
// timed phases. Phase lengths are latched at start. The select and
// output-valid strobes come from per-phase masks. The block also provides
// abort, auto-restart, a done pulse and sticky overrun detection.
module phase_sequencer_timer #(
  parameter int                    NUM_PHASES = 5,
  parameter int                    CNT_W      = 16,
  parameter logic [NUM_PHASES-1:0] SEL_MASK   = 5'b00110,
  parameter logic [NUM_PHASES-1:0] DOUT_MASK  = 5'b10000,
  parameter int                    IDX_W      = 3
) (
  input  logic                        S_AXIS_ACLK,
  input  logic                        S_AXIS_ARESET,
  input  logic                        Din_Valid,
  input  logic                        Abort,
  input  logic                        Auto_Restart,
  input  logic [NUM_PHASES*CNT_W-1:0] Phase_Len,
  output logic                        Sel_Valid,
  output logic                        Dout_Valid,
  output logic                        Busy,
  output logic [IDX_W-1:0]            Phase_Idx,
  output logic                        Done,
  output logic                        Overrun
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  typedef logic [NUM_PHASES-1:0][CNT_W-1:0] len_arr_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PHASES - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  len_arr_t         len_q, len_d;
  logic             sel_q, sel_d;
  logic             dout_q, dout_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;

  // Counter preload for a phase: a zero length runs as a single cycle.
  function automatic logic [CNT_W-1:0] first_cnt(input logic [CNT_W-1:0] l);
    return (l == '0) ? '0 : l - CNT_W'(1);
  endfunction

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    sel_d   = sel_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    idx_nxt = idx_q + IDX_W'(1);
    case (state_q)
      IDLE: begin
        if (Abort) begin
          ovr_d = 1'b0;
        end else if (Din_Valid) begin
          state_d = RUN;
          len_d   = Phase_Len;
          idx_d   = '0;
          cnt_d   = first_cnt(Phase_Len[CNT_W-1:0]);
          sel_d   = SEL_MASK[0];
          dout_d  = DOUT_MASK[0];
        end
      end
      RUN: begin
        if (Abort) begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
          sel_d   = 1'b0;
          dout_d  = 1'b0;
          ovr_d   = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (Din_Valid) ovr_d = 1'b1;
        end else if (idx_q != LAST_IDX) begin
          idx_d  = idx_nxt;
          cnt_d  = first_cnt(len_q[idx_nxt]);
          sel_d  = SEL_MASK[idx_nxt];
          dout_d = DOUT_MASK[idx_nxt];
          if (Din_Valid) ovr_d = 1'b1;
        end else begin
          // Terminal cycle of the last phase.
          done_d = 1'b1;
          if (Auto_Restart) begin
            len_d  = Phase_Len;
            idx_d  = '0;
            cnt_d  = first_cnt(Phase_Len[CNT_W-1:0]);
            sel_d  = SEL_MASK[0];
            dout_d = DOUT_MASK[0];
            if (Din_Valid) ovr_d = 1'b1;
          end else begin
            // A start request here is dropped and does not flag overrun.
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            sel_d   = 1'b0;
            dout_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      sel_q   <= 1'b0;
      dout_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      sel_q   <= sel_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign Sel_Valid  = sel_q;
  assign Dout_Valid = dout_q;
  assign Busy       = (state_q == RUN);
  assign Phase_Idx  = idx_q;
  assign Done       = done_q;
  assign Overrun    = ovr_q;

endmodule

// File: tb/tb_phase_sequencer_timer.sv
// Randomised and directed bench for phase_sequencer_timer. The reference
// model expands each sequence into a per-cycle schedule of phase numbers and
// pops one entry per clock.
module tb_phase_sequencer_timer;
  localparam int NP    = 5;
  localparam int CNT_W = 16;
  localparam int IDX_W = 3;
  localparam logic [NP-1:0] SEL_M  = 5'b00110;
  localparam logic [NP-1:0] DOUT_M = 5'b10000;

  logic                gclk = 1'b0;
  logic                rst, din, abrt, arst;
  logic [NP*CNT_W-1:0] pl;
  logic                sel_v, dout_v, busy, done, ovr;
  logic [IDX_W-1:0]    pidx;

  int n_cmp = 0;
  int n_err = 0;

  // model state
  int sched[$];
  bit m_done, m_ovr;
  int busy_cnt, sel_cnt, dout_cnt, done_cnt;

  always #5 gclk = ~gclk;

  phase_sequencer_timer #(
    .NUM_PHASES(NP), .CNT_W(CNT_W), .SEL_MASK(SEL_M), .DOUT_MASK(DOUT_M), .IDX_W(IDX_W)
  ) dut (
    .S_AXIS_ACLK(gclk), .S_AXIS_ARESET(rst), .Din_Valid(din), .Abort(abrt),
    .Auto_Restart(arst), .Phase_Len(pl), .Sel_Valid(sel_v), .Dout_Valid(dout_v),
    .Busy(busy), .Phase_Idx(pidx), .Done(done), .Overrun(ovr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expand the current Phase_Len into one schedule entry per cycle.
  task automatic build_sched();
    int n;
    sched.delete();
    for (int p = 0; p < NP; p++) begin
      n = int'(pl[p*CNT_W +: CNT_W]);
      if (n == 0) n = 1;
      for (int k = 0; k < n; k++) sched.push_back(p);
    end
  endtask

  // Advance the model by one clock edge using the inputs now applied.
  task automatic model_step();
    if (rst) begin
      sched.delete(); m_done = 0; m_ovr = 0;
    end else if (sched.size() != 0) begin
      if (abrt) begin
        sched.delete(); m_done = 0; m_ovr = 0;
      end else begin
        void'(sched.pop_front());
        if (sched.size() == 0) begin
          m_done = 1;
          if (arst) begin
            build_sched();
            if (din) m_ovr = 1;
          end
        end else begin
          m_done = 0;
          if (din) m_ovr = 1;
        end
      end
    end else begin
      m_done = 0;
      if (abrt) m_ovr = 0;
      else if (din) build_sched();
    end
  endtask

  task automatic check_outputs();
    int  ph;
    bit  b;
    b  = (sched.size() != 0);
    ph = b ? sched[0] : 0;
    chk("busy",  32'(busy),   32'(b));
    chk("idx",   32'(pidx),   32'(ph));
    chk("sel",   32'(sel_v),  32'(b && SEL_M[ph]));
    chk("dout",  32'(dout_v), 32'(b && DOUT_M[ph]));
    chk("done",  32'(done),   32'(m_done));
    chk("ovr",   32'(ovr),    32'(m_ovr));
    busy_cnt += int'(busy); sel_cnt += int'(sel_v);
    dout_cnt += int'(dout_v); done_cnt += int'(done);
  endtask

  // Apply one cycle of inputs at the falling edge, clock, then check.
  task automatic cyc(input logic r, input logic d, input logic a, input logic ar);
    rst = r; din = d; abrt = a; arst = ar;
    model_step();
    @(negedge gclk);
    check_outputs();
  endtask

  task automatic idle(input int n, input logic ar);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, ar);
  endtask

  task automatic clr_cnt();
    busy_cnt = 0; sel_cnt = 0; dout_cnt = 0; done_cnt = 0;
  endtask

  localparam logic [NP*CNT_W-1:0] PL54321 = {16'd5, 16'd4, 16'd3, 16'd2, 16'd1};

  initial begin
    rst = 1; din = 0; abrt = 0; arst = 0; pl = PL54321;
    m_done = 0; m_ovr = 0;
    clr_cnt();
    @(negedge gclk);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);   // reset dominates a start request

    // basic sequence: 15 busy cycles, 5 sel, 5 dout, one done
    clr_cnt();
    idle(3, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(24, 1'b0);
    chk("seq_busy_cycles", 32'(busy_cnt), 32'd15);
    chk("seq_sel_cycles",  32'(sel_cnt),  32'd5);
    chk("seq_dout_cycles", 32'(dout_cnt), 32'd5);
    chk("seq_done_pulses", 32'(done_cnt), 32'd1);

    // auto-restart with Phase_Len changed mid-run
    clr_cnt();
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    idle(8, 1'b1);
    pl = {16'd1, 16'd1, 16'd1, 16'd1, 16'd2};
    idle(10, 1'b1);
    idle(10, 1'b0);
    chk("ar_busy_cycles", 32'(busy_cnt), 32'd21);
    chk("ar_done_pulses", 32'(done_cnt), 32'd2);

    // all-zero lengths, then restart in the Done cycle
    pl = '0;
    clr_cnt();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(5, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(7, 1'b0);
    chk("zero_busy_cycles", 32'(busy_cnt), 32'd10);
    chk("zero_sel_cycles",  32'(sel_cnt),  32'd4);

    // abort during phase 2, then start+abort together in IDLE
    pl = PL54321;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(4, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    idle(3, 1'b0);

    // overrun set by a re-pulse in RUN, cleared by abort
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(5, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b0);

    // start request on the last terminal cycle is dropped silently
    pl = {16'd2, 16'd1, 16'd1, 16'd1, 16'd1};
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(5, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b0);

    // reset mid-sequence, then fresh start
    pl = PL54321;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(7, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(20, 1'b0);

    // randomised traffic
    for (int i = 0; i < 4000; i++) begin
      logic [NP*CNT_W-1:0] npl;
      if ($urandom_range(0, 15) == 0) begin
        npl = '0;
        for (int p = 0; p < NP; p++)
          npl[p*CNT_W +: CNT_W] = ($urandom_range(0, 19) == 0) ?
                                  CNT_W'($urandom_range(5, 25)) : CNT_W'($urandom_range(0, 4));
        pl = npl;
      end
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 6) == 0),
          ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
